// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

    localparam int DATA_BITS = 8;

    // Clock cycles per bit; callers must keep the result >= 16 so the
    // half-bit start offset leaves room for the synchroniser delay.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate down-counter: tick_o marks expiry (count==0) and the counter
// reloads a full bit period on its own, so consecutive ticks are DIV apart.
module uart_baud_tick #(
    parameter int DIV = 868
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_half,
    input  logic load_full,
    input  logic enable,
    output logic tick_o
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    assign tick_o = enable && (cnt == '0);

    // Load has priority; otherwise count down while enabled, reloading on expiry.
    always_ff @(posedge clk_i) begin
        if (rst_i)                  cnt <= '0;
        else if (load_half)         cnt <= CW'(DIV / 2 - 1);
        else if (load_full || tick_o) cnt <= CW'(DIV - 1);
        else if (enable)            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8 data bits LSB first, optional even parity, 1 or 2 stop
// bits. Each byte is reported with a one-cycle valid pulse plus error flags.
module uart_rx_core #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       parity_en_i,
    input  logic       stopbit_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    import uart_pkg::*;

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_rx_state_t state, state_next;

    logic sync1, rx_s, rx_s_prev, fall;
    logic load_half, load_full, tick, done;
    logic [BW-1:0] bit_cnt;
    logic stop_cnt, par_en_q, stop2_q, perr_acc, ferr_acc;
    logic [DATA_BITS-1:0] shift;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            rx_s_prev <= 1'b1;
        end else begin
            sync1     <= rx_i;
            rx_s      <= sync1;
            rx_s_prev <= rx_s;
        end
    end

    assign fall   = rx_s_prev & ~rx_s;
    assign busy_o = (state != IDLE);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_half (load_half),
        .load_full (load_full),
        .enable    (busy_o),
        .tick_o    (tick)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; leaving STOP at the last mid-bit sample keeps a
    // back-to-back start edge from being missed.
    always_comb begin
        state_next = state;
        load_half  = 1'b0;
        load_full  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:   if (fall) begin
                        load_half  = 1'b1;
                        state_next = START;
                    end
            START:  if (tick) begin
                        if (rx_s) state_next = IDLE;
                        else begin
                            load_full  = 1'b1;
                            state_next = DATA;
                        end
                    end
            DATA:   if (tick && bit_cnt == LAST_BIT)
                        state_next = par_en_q ? PARITY : STOP;
            PARITY: if (tick) state_next = STOP;
            STOP:   if (tick && (!stop2_q || stop_cnt)) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: frame config latch, shift register, error accumulation, outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            par_en_q     <= 1'b0;
            stop2_q      <= 1'b0;
            perr_acc     <= 1'b0;
            ferr_acc     <= 1'b0;
            shift        <= '0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            if (state == IDLE && fall) begin
                par_en_q <= parity_en_i;
                stop2_q  <= stopbit_i;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                perr_acc <= 1'b0;
                ferr_acc <= 1'b0;
            end
            if (tick) begin
                case (state)
                    DATA: begin
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: perr_acc <= rx_s ^ (^shift);
                    STOP: begin
                        stop_cnt <= 1'b1;
                        if (!rx_s) ferr_acc <= 1'b1;
                        if (done) begin
                            rx_valid_o   <= 1'b1;
                            rx_data_o    <= shift;
                            parity_err_o <= perr_acc;
                            frame_err_o  <= ferr_acc | ~rx_s;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core. Runs at a reduced divider (32 cycles
// per bit) so many frames fit in a short run; expectations come from the
// frame rules (even parity, stop-bit values, bit-period latency).
module tb_uart_rx_core;

    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 3_125_000;
    localparam int DIV      = CLK_FREQ / BAUD;

    logic       clk, rst_i, rx_i, parity_en_i, stopbit_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, parity_err_o, frame_err_o, busy_o;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         cyc;
    } rec_t;

    rec_t got[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .parity_en_i  (parity_en_i),
        .stopbit_i    (stopbit_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every valid pulse with the cycle it was seen.
    always @(negedge clk) if (rx_valid_o) got.push_back('{rx_data_o, parity_err_o, frame_err_o, cyc});

    // Drive the line for n cycles, ending just after a rising edge.
    task automatic hold(input logic v, input int n);
        rx_i = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: serialise one frame and return what the receiver should report.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic s2,
                              input logic bad_par, input logic [1:0] stops,
                              input logic scramble, output rec_t e);
        int start;
        parity_en_i = pe;
        stopbit_i   = s2;
        start = cyc;
        hold(1'b0, DIV);
        if (scramble) begin
            parity_en_i = ~pe;
            stopbit_i   = ~s2;
        end
        for (int i = 0; i < 8; i++) hold(d[i], DIV);
        if (pe) hold((^d) ^ bad_par, DIV);
        hold(stops[0], DIV);
        if (s2) hold(stops[1], DIV);
        e.d   = d;
        e.pe  = pe & bad_par;
        e.fe  = ~stops[0] | (s2 & ~stops[1]);
        e.cyc = start + (9 + int'(pe) + int'(s2)) * DIV + DIV / 2 + 3;
    endtask

    task automatic test_reset();
        rst_i = 1; rx_i = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data_o); end
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid_o); end
        checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        @(posedge clk); #1;
        rst_i = 0;
        hold(1'b1, 4);
    endtask

    task automatic test_single();
        rec_t e;
        got.delete();
        send_frame(8'h1C, 1, 1, 0, 2'b11, 0, e);
        hold(1'b1, DIV);
        checks++; if (got.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", got.size()); end
        if (got.size() >= 1) begin
            checks++; if (got[0].d !== 8'h1C) begin errors++; $display("FAIL single_data: got %h want 1c", got[0].d); end
            checks++; if (got[0].pe !== 1'b0 || got[0].fe !== 1'b0) begin errors++; $display("FAIL single_flags: got pe=%b fe=%b want 0 0", got[0].pe, got[0].fe); end
            checks++; if (got[0].cyc < e.cyc - 1 || got[0].cyc > e.cyc + 1) begin errors++; $display("FAIL single_latency: got cycle %0d want %0d+-1", got[0].cyc, e.cyc); end
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        rec_t e;
        logic [7:0] bytes [3];
        bytes[0] = 8'h0D; bytes[1] = 8'h0D; bytes[2] = 8'h7F;
        got.delete();
        for (int i = 0; i < 3; i++) send_frame(bytes[i], 1, 0, 0, 2'b11, 0, e);
        hold(1'b1, DIV);
        checks++; if (got.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                checks++;
                if (got[i].d !== bytes[i] || got[i].pe !== 1'b0 || got[i].fe !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_frame%0d: got %h pe=%b fe=%b want %h 0 0", i, got[i].d, got[i].pe, got[i].fe, bytes[i]);
                end
            end
        end
    endtask

    task automatic test_parity_err();
        rec_t e;
        got.delete();
        send_frame(8'h7F, 1, 1, 1, 2'b11, 0, e);
        hold(1'b1, DIV);
        checks++; if (got.size() != 1) begin errors++; $display("FAIL perr_count: got %0d want 1", got.size()); end
        if (got.size() >= 1) begin
            checks++; if (got[0].d !== 8'h7F) begin errors++; $display("FAIL perr_data: got %h want 7f", got[0].d); end
            checks++; if (got[0].pe !== 1'b1 || got[0].fe !== 1'b0) begin errors++; $display("FAIL perr_flags: got pe=%b fe=%b want 1 0", got[0].pe, got[0].fe); end
        end
    endtask

    task automatic test_frame_err();
        rec_t e;
        got.delete();
        send_frame(8'h55, 0, 0, 0, 2'b10, 0, e);
        hold(1'b1, 2 * DIV);
        checks++; if (got.size() != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", got.size()); end
        if (got.size() >= 1) begin
            checks++; if (got[0].d !== 8'h55) begin errors++; $display("FAIL ferr_data: got %h want 55", got[0].d); end
            checks++; if (got[0].fe !== 1'b1 || got[0].pe !== 1'b0) begin errors++; $display("FAIL ferr_flags: got pe=%b fe=%b want 0 1", got[0].pe, got[0].fe); end
        end
    endtask

    task automatic test_glitch();
        int t0, fell;
        logic seen;
        got.delete();
        seen = 0; fell = -1;
        t0 = cyc;
        hold(1'b0, 8);
        rx_i = 1;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            if (busy_o) seen = 1;
            else if (seen && fell < 0) fell = cyc;
        end
        @(posedge clk); #1;
        checks++; if (fell < 0) begin errors++; $display("FAIL glitch_busy: busy never rose and fell within %0d cycles", 4 * DIV); end
        checks++; if (fell - t0 < DIV / 2 + 2 || fell - t0 > DIV / 2 + 4) begin errors++; $display("FAIL glitch_busy_time: got %0d want %0d+-1", fell - t0, DIV / 2 + 3); end
        checks++; if (got.size() != 0) begin errors++; $display("FAIL glitch_valid: got %0d pulses want 0", got.size()); end
    endtask

    task automatic test_break();
        got.delete();
        parity_en_i = 0; stopbit_i = 0;
        hold(1'b0, 20 * DIV);
        checks++; if (got.size() != 1) begin errors++; $display("FAIL break_count: got %0d want 1", got.size()); end
        if (got.size() >= 1) begin
            checks++;
            if (got[0].d !== 8'h00 || got[0].fe !== 1'b1 || got[0].pe !== 1'b0) begin
                errors++;
                $display("FAIL break_frame: got %h pe=%b fe=%b want 00 0 1", got[0].d, got[0].pe, got[0].fe);
            end
        end
        hold(1'b1, 3 * DIV);
        checks++; if (got.size() != 1) begin errors++; $display("FAIL break_restart: got %0d pulses want 1", got.size()); end
    endtask

    task automatic test_reset_midframe();
        rec_t e;
        logic [7:0] d;
        d = 8'hA5;
        got.delete();
        parity_en_i = 1; stopbit_i = 1;
        hold(1'b0, DIV);
        for (int i = 0; i < 4; i++) hold(d[i], DIV);
        hold(d[4], DIV / 2);
        // The sender abandons the frame along with the reset, returning the line to idle.
        rst_i = 1; rx_i = 1;
        @(posedge clk); #1;
        rst_i = 0;
        @(negedge clk);
        checks++;
        if (rx_data_o !== 8'h00 || rx_valid_o !== 1'b0 || parity_err_o !== 1'b0 || frame_err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got data=%h v=%b pe=%b fe=%b busy=%b want all 0",
                     rx_data_o, rx_valid_o, parity_err_o, frame_err_o, busy_o);
        end
        @(posedge clk); #1;
        hold(1'b1, 12 * DIV);
        checks++; if (got.size() != 0) begin errors++; $display("FAIL midreset_valid: got %0d pulses want 0", got.size()); end
        send_frame(8'h3C, 1, 1, 0, 2'b11, 0, e);
        hold(1'b1, DIV);
        checks++; if (got.size() != 1) begin errors++; $display("FAIL midreset_next_count: got %0d want 1", got.size()); end
        if (got.size() >= 1) begin
            checks++;
            if (got[0].d !== 8'h3C || got[0].pe !== 1'b0 || got[0].fe !== 1'b0) begin
                errors++;
                $display("FAIL midreset_next: got %h pe=%b fe=%b want 3c 0 0", got[0].d, got[0].pe, got[0].fe);
            end
        end
    endtask

    task automatic test_random();
        rec_t e;
        rec_t exp_q[$];
        logic [7:0] d;
        logic pe, s2, bad, last;
        logic [1:0] stops;
        got.delete();
        for (int n = 0; n < 8; n++) begin
            d     = 8'($urandom);
            pe    = 1'($urandom_range(0, 1));
            s2    = 1'($urandom_range(0, 1));
            bad   = ($urandom_range(0, 3) == 0);
            stops = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            send_frame(d, pe, s2, bad, stops, 1, e);
            exp_q.push_back(e);
            last = s2 ? stops[1] : stops[0];
            if (!last) hold(1'b1, DIV);
            hold(1'b1, $urandom_range(0, DIV));
        end
        hold(1'b1, DIV);
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) begin
                checks++;
                if (got[i].d !== exp_q[i].d || got[i].pe !== exp_q[i].pe || got[i].fe !== exp_q[i].fe ||
                    got[i].cyc < exp_q[i].cyc - 1 || got[i].cyc > exp_q[i].cyc + 1) begin
                    errors++;
                    $display("FAIL rand_frame%0d: got %h pe=%b fe=%b cyc=%0d want %h pe=%b fe=%b cyc=%0d",
                             i, got[i].d, got[i].pe, got[i].fe, got[i].cyc,
                             exp_q[i].d, exp_q[i].pe, exp_q[i].fe, exp_q[i].cyc);
                end
            end
        end
    endtask

    initial begin
        rst_i = 1; rx_i = 1; parity_en_i = 0; stopbit_i = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_parity_err();
        test_frame_err();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within 100000 cycles");
        $fatal(1, "timeout");
    end

endmodule
